riscv_mul_issue_wb: RTL and testbench



---
 rtl/riscv_mul_pkg.sv | 23 ++
 rtl/riscv_mul_prod_cache.sv | 35 +++
 rtl/riscv_mul_issue_wb.sv | 107 ++++++++++
 tb/tb_riscv_mul_issue_wb.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mul_pkg.sv
// riscv_mul_pkg: shared constants and types for the multiply issue/writeback sequencer.
package riscv_mul_pkg;
  localparam logic [3:0] ALU_ADD  = 4'b0100;
  localparam logic [3:0] ALU_MULL = 4'b1100;
  localparam logic MUL_SEL_LO = 1'b0;
  localparam logic MUL_SEL_HI = 1'b1;
  typedef enum logic [2:0] {
    MUL_ST_IDLE,
    MUL_ST_LAUNCH,
    MUL_ST_WAIT,
    MUL_ST_DONE,
    MUL_ST_DRAIN
  } mul_st_e;
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        a_signed;
    logic        b_signed;
  } mul_tag_t;
  function automatic logic [31:0] sel_word(input logic [63:0] prod, input logic hi);
    return (hi == MUL_SEL_HI) ? prod[63:32] : prod[31:0];
  endfunction
endpackage

// File: rtl/riscv_mul_prod_cache.sv
// riscv_mul_prod_cache: one-entry product store keyed on operands and signedness.
module riscv_mul_prod_cache
  import riscv_mul_pkg::*;
#(
  parameter bit CACHE_EN = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inv_i,
  input  logic        wr_i,
  input  mul_tag_t    wr_tag_i,
  input  logic [63:0] wr_prod_i,
  input  mul_tag_t    rd_tag_i,
  output logic        hit_o,
  output logic [63:0] prod_o
);
  logic        valid_q;
  mul_tag_t    tag_q;
  logic [63:0] prod_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      prod_q  <= '0;
    end else if (inv_i) begin
      valid_q <= 1'b0;
    end else if (wr_i) begin
      valid_q <= 1'b1;
      tag_q   <= wr_tag_i;
      prod_q  <= wr_prod_i;
    end
  end
  assign hit_o  = CACHE_EN && valid_q && (rd_tag_i == tag_q);
  assign prod_o = prod_q;
endmodule

// File: rtl/riscv_mul_issue_wb.sv
// riscv_mul_issue_wb: launches the EX multiplier, waits out its stall and hands
// the selected product word to writeback, reusing the last product when possible.
module riscv_mul_issue_wb
  import riscv_mul_pkg::*;
#(
  parameter int TIMEOUT_CYC = 40,
  parameter bit CACHE_EN    = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_hi_i,
  input  logic        req_a_signed_i,
  input  logic        req_b_signed_i,
  input  logic [31:0] req_a_i,
  input  logic [31:0] req_b_i,
  input  logic [4:0]  req_rd_i,
  output logic [3:0]  mul_op_o,
  output logic        mul_a_signed_o,
  output logic        mul_b_signed_o,
  output logic [31:0] mul_a_o,
  output logic [31:0] mul_b_o,
  input  logic [63:0] mul_res_i,
  input  logic        mul_stall_i,
  output logic        wb_valid_o,
  input  logic        wb_ready_i,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic        wb_reused_o,
  input  logic        flush_i,
  output logic        timeout_o
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  mul_st_e     state_q, state_d;
  mul_tag_t    tag_q, req_tag;
  logic        hi_q, reused_q;
  logic [4:0]  rd_q;
  logic [31:0] data_q;
  logic [CW-1:0] cnt_q;
  logic        accept, hit, busy, capture, timeout;
  logic [63:0] cache_prod;
  assign req_tag     = '{a: req_a_i, b: req_b_i, a_signed: req_a_signed_i, b_signed: req_b_signed_i};
  assign req_ready_o = (state_q == MUL_ST_IDLE) && !flush_i;
  assign accept      = req_valid_i && req_ready_o;
  assign busy        = (state_q == MUL_ST_WAIT) || (state_q == MUL_ST_DRAIN);
  assign capture     = busy && !mul_stall_i;
  // A flush in WAIT wins over the watchdog; DRAIN ignores flush.
  assign timeout     = busy && mul_stall_i && (cnt_q == CW'(TIMEOUT_CYC - 1)) &&
                       !((state_q == MUL_ST_WAIT) && flush_i);
  riscv_mul_prod_cache #(.CACHE_EN(CACHE_EN)) u_cache (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .inv_i    (timeout),
    .wr_i     (capture),
    .wr_tag_i (tag_q),
    .wr_prod_i(mul_res_i),
    .rd_tag_i (req_tag),
    .hit_o    (hit),
    .prod_o   (cache_prod)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      MUL_ST_IDLE:   state_d = accept ? (hit ? MUL_ST_DONE : MUL_ST_LAUNCH) : MUL_ST_IDLE;
      MUL_ST_LAUNCH: state_d = flush_i ? MUL_ST_DRAIN : MUL_ST_WAIT;
      MUL_ST_WAIT:   state_d = flush_i ? MUL_ST_DRAIN : timeout ? MUL_ST_IDLE :
                               !mul_stall_i ? MUL_ST_DONE : MUL_ST_WAIT;
      MUL_ST_DONE:   state_d = (flush_i || wb_ready_i) ? MUL_ST_IDLE : MUL_ST_DONE;
      MUL_ST_DRAIN:  state_d = (timeout || !mul_stall_i) ? MUL_ST_IDLE : MUL_ST_DRAIN;
      default:       state_d = MUL_ST_IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= MUL_ST_IDLE;
      tag_q    <= '0;
      hi_q     <= 1'b0;
      rd_q     <= '0;
      data_q   <= '0;
      reused_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= busy ? cnt_q + 1'b1 : '0;
      if (accept) begin
        tag_q    <= req_tag;
        hi_q     <= req_hi_i;
        rd_q     <= req_rd_i;
        reused_q <= hit;
        if (hit) data_q <= sel_word(cache_prod, req_hi_i);
      end else if ((state_q == MUL_ST_WAIT) && capture && !flush_i) begin
        data_q <= sel_word(mul_res_i, hi_q);
      end
    end
  end
  assign mul_op_o       = (state_q == MUL_ST_LAUNCH) ? ALU_MULL : ALU_ADD;
  assign mul_a_o        = tag_q.a;
  assign mul_b_o        = tag_q.b;
  assign mul_a_signed_o = tag_q.a_signed;
  assign mul_b_signed_o = tag_q.b_signed;
  assign wb_valid_o     = (state_q == MUL_ST_DONE);
  assign wb_rd_o        = rd_q;
  assign wb_data_o      = data_q;
  assign wb_reused_o    = reused_q;
  assign timeout_o      = timeout;
endmodule

// File: tb/tb_riscv_mul_issue_wb.sv
// tb_riscv_mul_issue_wb: directed table-driven checks plus hand-written flush, timeout and reset sequences.
module tb_riscv_mul_issue_wb;
  import riscv_mul_pkg::*;
  logic        clk_i = 0, rst_i = 1;
  logic        req_valid_i = 0, req_hi_i = 0, req_a_signed_i = 0, req_b_signed_i = 0;
  logic [31:0] req_a_i = 0, req_b_i = 0;
  logic [4:0]  req_rd_i = 0;
  logic        req_ready_o, mul_a_signed_o, mul_b_signed_o, mul_stall_i;
  logic [3:0]  mul_op_o;
  logic [31:0] mul_a_o, mul_b_o, wb_data_o;
  logic [63:0] mul_res_i;
  logic        wb_valid_o, wb_ready_i = 0, wb_reused_o, flush_i = 0, timeout_o;
  logic [4:0]  wb_rd_o;
  int n_checks = 0, n_fail = 0;
  int seq_lat = 0, busy = 0, mull_cnt = 0;
  logic force_stall = 0;
  typedef struct {
    logic hi, as, bs;
    logic [31:0] a, b;
    logic [4:0] rd;
    logic [31:0] exp;
    logic reused;
  } vec_t;
  riscv_mul_issue_wb #(.TIMEOUT_CYC(40), .CACHE_EN(1'b1)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_hi_i(req_hi_i), .req_a_signed_i(req_a_signed_i), .req_b_signed_i(req_b_signed_i),
    .req_a_i(req_a_i), .req_b_i(req_b_i), .req_rd_i(req_rd_i), .mul_op_o(mul_op_o),
    .mul_a_signed_o(mul_a_signed_o), .mul_b_signed_o(mul_b_signed_o), .mul_a_o(mul_a_o),
    .mul_b_o(mul_b_o), .mul_res_i(mul_res_i), .mul_stall_i(mul_stall_i), .wb_valid_o(wb_valid_o),
    .wb_ready_i(wb_ready_i), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o), .wb_reused_o(wb_reused_o),
    .flush_i(flush_i), .timeout_o(timeout_o)
  );
  always #5 clk_i = ~clk_i;
  function automatic logic [63:0] prod(input logic [31:0] a, input logic [31:0] b, input logic as, input logic bs);
    logic [63:0] x, y;
    x = {{32{as & a[31]}}, a};
    y = {{32{bs & b[31]}}, b};
    return x * y;
  endfunction
  assign mul_res_i   = prod(mul_a_o, mul_b_o, mul_a_signed_o, mul_b_signed_o);
  assign mul_stall_i = force_stall || (busy != 0);
  always @(posedge clk_i) begin
    if (rst_i) busy <= 0;
    else if (mul_op_o == ALU_MULL) busy <= seq_lat;
    else if (busy != 0) busy <= busy - 1;
    if (!rst_i && mul_op_o == ALU_MULL) mull_cnt <= mull_cnt + 1;
  end
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic drive_req(input vec_t v);
    @(negedge clk_i);
    req_hi_i = v.hi; req_a_signed_i = v.as; req_b_signed_i = v.bs;
    req_a_i = v.a; req_b_i = v.b; req_rd_i = v.rd; req_valid_i = 1;
    check("req_ready_before_accept", req_ready_o, 1);
    @(posedge clk_i); #1;
    req_valid_i = 0;
  endtask
  task automatic wait_valid(input vec_t v, output int lat, output bit ops_ok);
    lat = 1; ops_ok = 1;
    @(negedge clk_i);
    while (!wb_valid_o && lat < 100) begin
      if (mul_a_o !== v.a || mul_b_o !== v.b) ops_ok = 0;
      @(negedge clk_i);
      lat++;
    end
  endtask
  task automatic finish_wb();
    wb_ready_i = 1;
    @(posedge clk_i); #1;
    wb_ready_i = 0;
    @(negedge clk_i);
    check("valid_drops_after_handshake", wb_valid_o, 0);
  endtask
  task automatic run_vec(input vec_t v, input int exp_lat, input int exp_mull);
    int lat, m0;
    bit ok;
    m0 = mull_cnt;
    drive_req(v);
    wait_valid(v, lat, ok);
    check("wb_data", wb_data_o, v.exp);
    check("wb_rd", wb_rd_o, v.rd);
    check("wb_reused", wb_reused_o, v.reused);
    check("latency", lat, exp_lat);
    check("mull_pulses", mull_cnt - m0, exp_mull);
    check("ops_held", ok, 1);
  endtask
  vec_t tbl[12];
  initial begin
    vec_t v;
    int lat, cyc;
    bit ok, bad_ready, bad_valid;
    tbl[0]  = '{0, 0, 0, 32'd8, 32'd8, 5'd1, 32'h00000040, 0};
    tbl[1]  = '{1, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'hFFFFFFFE, 0};
    tbl[2]  = '{0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'h00000001, 1};
    tbl[3]  = '{1, 1, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 32'h00000000, 0};
    tbl[4]  = '{0, 1, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5, 32'h00000001, 1};
    tbl[5]  = '{1, 1, 1, 32'h80000000, 32'd2, 5'd6, 32'hFFFFFFFF, 0};
    tbl[6]  = '{1, 1, 0, 32'hFFFFFFFF, 32'd2, 5'd7, 32'hFFFFFFFF, 0};
    tbl[7]  = '{0, 1, 0, 32'hFFFFFFFF, 32'd2, 5'd8, 32'hFFFFFFFE, 1};
    tbl[8]  = '{0, 0, 0, 32'h12345678, 32'h10, 5'd9, 32'h23456780, 0};
    tbl[9]  = '{1, 0, 0, 32'h12345678, 32'h10, 5'd10, 32'h00000001, 1};
    tbl[10] = '{1, 0, 0, 32'h00010000, 32'h00010000, 5'd11, 32'h00000001, 0};
    tbl[11] = '{1, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd12, 32'hFFFFFFFF, 0};
    repeat (2) @(posedge clk_i);
    #1 rst_i = 0;
    @(negedge clk_i);
    check("rst_req_ready", req_ready_o, 1);
    check("rst_mul_op", mul_op_o, ALU_ADD);
    check("rst_wb_valid", wb_valid_o, 0);
    check("rst_wb_data", wb_data_o, 0);
    check("rst_timeout", timeout_o, 0);
    for (int i = 0; i < 12; i++) begin
      run_vec(tbl[i], tbl[i].reused ? 1 : 3, tbl[i].reused ? 0 : 1);
      finish_wb();
    end
    // signed MULH with writeback back-pressure
    v = '{1, 1, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd14, 32'h00000000, 0};
    run_vec(v, 3, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      check("hold_valid", wb_valid_o, 1);
      check("hold_data", wb_data_o, 0);
      check("hold_req_ready", req_ready_o, 0);
    end
    finish_wb();
    // sequential multiplier
    seq_lat = 32;
    v = '{0, 0, 0, 32'd7, 32'd9, 5'd13, 32'h0000003F, 0};
    run_vec(v, 35, 1);
    finish_wb();
    // flush in IDLE blocks accept
    @(negedge clk_i);
    flush_i = 1;
    #1 check("flush_idle_ready", req_ready_o, 0);
    @(posedge clk_i); #1 flush_i = 0;
    // flush during WAIT -> DRAIN until stall drops
    v = '{0, 0, 0, 32'd3, 32'd5, 5'd15, 32'd15, 0};
    drive_req(v);
    @(negedge clk_i);
    @(negedge clk_i);
    check("wait_stalled", mul_stall_i, 1);
    flush_i = 1;
    @(posedge clk_i); #1 flush_i = 0;
    bad_ready = 0; bad_valid = 0; cyc = 0;
    @(negedge clk_i);
    while (mul_stall_i && cyc < 60) begin
      if (req_ready_o) bad_ready = 1;
      if (wb_valid_o) bad_valid = 1;
      @(negedge clk_i);
      cyc++;
    end
    check("drain_stall_dropped", mul_stall_i, 0);
    check("drain_ready_low", bad_ready | req_ready_o, 0);
    check("drain_no_valid", bad_valid | wb_valid_o, 0);
    @(negedge clk_i);
    check("drain_ready_after", req_ready_o, 1);
    seq_lat = 0;
    v.rd = 5'd16; v.reused = 1;
    run_vec(v, 1, 0);
    finish_wb();
    // flush in DONE drops valid
    v = '{0, 0, 0, 32'd6, 32'd7, 5'd17, 32'd42, 0};
    run_vec(v, 3, 1);
    flush_i = 1;
    @(posedge clk_i); #1 flush_i = 0;
    @(negedge clk_i);
    check("flush_done_valid", wb_valid_o, 0);
    check("flush_done_ready", req_ready_o, 1);
    // watchdog
    force_stall = 1;
    v = '{0, 0, 0, 32'd4, 32'd5, 5'd18, 32'd20, 0};
    drive_req(v);
    lat = 1; bad_valid = 0;
    @(negedge clk_i);
    while (!timeout_o && lat < 60) begin
      if (wb_valid_o) bad_valid = 1;
      @(negedge clk_i);
      lat++;
    end
    check("timeout_cycle", lat, 41);
    check("timeout_no_valid", bad_valid, 0);
    @(negedge clk_i);
    check("timeout_pulse_once", timeout_o, 0);
    check("timeout_back_idle", req_ready_o, 1);
    force_stall = 0;
    v = '{0, 0, 0, 32'd6, 32'd7, 5'd19, 32'd42, 0};
    run_vec(v, 3, 1);
    finish_wb();
    // reset in the middle of WAIT
    seq_lat = 32;
    v = '{1, 1, 1, 32'd9, 32'd9, 5'd20, 32'd0, 0};
    drive_req(v);
    repeat (5) @(negedge clk_i);
    rst_i = 1;
    @(negedge clk_i);
    rst_i = 0;
    check("mid_rst_ready", req_ready_o, 1);
    check("mid_rst_op", mul_op_o, ALU_ADD);
    check("mid_rst_a", mul_a_o, 0);
    check("mid_rst_b", mul_b_o, 0);
    check("mid_rst_signed", {mul_a_signed_o, mul_b_signed_o}, 0);
    check("mid_rst_valid", wb_valid_o, 0);
    check("mid_rst_rd", wb_rd_o, 0);
    check("mid_rst_data", wb_data_o, 0);
    check("mid_rst_reused", wb_reused_o, 0);
    check("mid_rst_timeout", timeout_o, 0);
    seq_lat = 0;
    v = '{0, 0, 0, 32'd6, 32'd7, 5'd21, 32'd42, 0};
    run_vec(v, 3, 1);
    finish_wb();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
